// File: rtl/plic_mc_pkg.sv
// Shared PLIC types, register-map offsets and byte-mask helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package plic_mc_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_MASK_W = MEM_DATA_W / 8;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_type_e;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] req_addr;
        logic [MEM_DATA_W-1:0] req_data;
        logic [MEM_MASK_W-1:0] req_mask;
        mem_type_e             req_type;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] resp_data;
        logic                  resp_last;
    } mem_resp_t;

    // Priorities sit at word 0..N-1; everything else is relative to N.
    localparam int PLIC_PRI_OFS    = 0;
    localparam int PLIC_PEND_OFS   = 0;
    localparam int PLIC_MODE_OFS   = 1;
    localparam int PLIC_CTX_BASE   = 2;
    localparam int PLIC_CTX_STRIDE = 3;
    localparam int PLIC_ENABLE_OFS = 0;
    localparam int PLIC_THRES_OFS  = 1;
    localparam int PLIC_CLAIM_OFS  = 2;

    // Word index of a per-context register.
    function automatic int ctx_idx(input int irq_n, input int ctx, input int sub);
        return irq_n + PLIC_CTX_BASE + PLIC_CTX_STRIDE * ctx + sub;
    endfunction

    // Merge new data into old data for every byte lane whose mask bit is set.
    function automatic logic [MEM_DATA_W-1:0] apply_mask(
        input logic [MEM_DATA_W-1:0] old_v,
        input logic [MEM_DATA_W-1:0] new_v,
        input logic [MEM_MASK_W-1:0] mask
    );
        logic [MEM_DATA_W-1:0] r;
        r = old_v;
        for (int b = 0; b < MEM_MASK_W; b++) begin
            if (mask[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/plic_mc_arbiter.sv
// Per-context priority arbiter: highest priority wins, lowest ID on ties.
// Latency: combinational.
// Backpressure: none.
module plic_arbiter #(
    parameter int IRQ_N   = 32,
    parameter int PRI_W   = 3,
    parameter int CLAIM_W = $clog2(IRQ_N)
) (
    input  logic [IRQ_N-1:0]            eligible,
    input  logic [IRQ_N-1:0][PRI_W-1:0] pri,
    output logic [CLAIM_W-1:0]          win_id,
    output logic [PRI_W-1:0]            win_pri
);

    // Linear scan; strict greater-than keeps the earlier (lower) ID on ties.
    always_comb begin
        win_id  = '0;
        win_pri = '0;
        for (int i = 0; i < IRQ_N; i++) begin
            if (eligible[i] && (pri[i] > win_pri)) begin
                win_id  = CLAIM_W'(i);
                win_pri = pri[i];
            end
        end
    end

endmodule

// File: rtl/plic_mc.sv
// Multi-context PLIC: gateways, per-context arbitration, claim/complete over mem_if.
// Latency: bus response 1 cycle after accept; ext_irq 1 cycle after state change.
// Backpressure: one outstanding transaction; req_ready low until resp is taken.
module plic_mc
    import plic_mc_pkg::*;
#(
    parameter int PLIC_IRQ_N      = 32,
    parameter int PLIC_CTX_N      = 2,
    parameter int PLIC_PRI_W      = 3,
    parameter int PLIC_EDGE_CNT_W = 2,
    parameter int PLIC_CLAIM_W    = $clog2(PLIC_IRQ_N),
    parameter int PLIC_ADDR_W     = $clog2(PLIC_IRQ_N + 2 + 3 * PLIC_CTX_N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req_valid,
    output logic                  mem_req_ready,
    input  mem_req_t              mem_req,
    output logic                  mem_resp_valid,
    input  logic                  mem_resp_ready,
    output mem_resp_t             mem_resp,
    input  logic [PLIC_IRQ_N-1:0] ext_irq_src,
    output logic [PLIC_CTX_N-1:0] ext_irq
);

    localparam int IDX_PEND = PLIC_IRQ_N + PLIC_PEND_OFS;
    localparam int IDX_MODE = PLIC_IRQ_N + PLIC_MODE_OFS;
    localparam logic [PLIC_IRQ_N-1:0] SRC_MASK = {{(PLIC_IRQ_N-1){1'b1}}, 1'b0};

    logic [PLIC_IRQ_N-1:0][PLIC_PRI_W-1:0]      pri;
    logic [PLIC_IRQ_N-1:0]                      mode, pend, gw_closed, pri_nz;
    logic [PLIC_IRQ_N-1:0][PLIC_EDGE_CNT_W-1:0] cnt;
    logic [PLIC_CTX_N-1:0][PLIC_IRQ_N-1:0]      en, elig;
    logic [PLIC_CTX_N-1:0][PLIC_PRI_W-1:0]      thr, win_pri;
    logic [PLIC_CTX_N-1:0][PLIC_CLAIM_W-1:0]    win_id;

    logic [PLIC_IRQ_N-1:0] s1, s2, s3, rise;
    logic [PLIC_IRQ_N-1:0] pend_n, gw_n, claim_clr, cmpl_hit;
    logic [PLIC_IRQ_N-1:0][PLIC_EDGE_CNT_W-1:0] cnt_n;

    logic                   busy, accept, is_wr;
    logic [PLIC_ADDR_W-1:0] word_idx;
    int                     widx;
    logic [MEM_DATA_W-1:0]  rdata, resp_data, cmpl_word;
    logic                   unused_addr;

    assign mem_req_ready      = ~busy;
    assign mem_resp_valid     = busy;
    assign mem_resp.resp_data = resp_data;
    assign mem_resp.resp_last = busy;

    assign accept    = mem_req_valid & mem_req_ready;
    assign is_wr     = (mem_req.req_type == MEM_WRITE);
    assign word_idx  = mem_req.req_addr[PLIC_ADDR_W+1:2];
    assign widx      = int'(word_idx);
    assign cmpl_word = apply_mask('0, mem_req.req_data, mem_req.req_mask);
    assign rise      = s2 & ~s3;
    assign unused_addr = ^{mem_req.req_addr[MEM_ADDR_W-1:PLIC_ADDR_W+2], mem_req.req_addr[1:0]};

    // Priority-zero sources never compete.
    always_comb begin
        pri_nz = '0;
        for (int i = 0; i < PLIC_IRQ_N; i++) pri_nz[i] = |pri[i];
    end

    genvar gc;
    generate
        for (gc = 0; gc < PLIC_CTX_N; gc++) begin : g_ctx
            assign elig[gc] = pend & en[gc] & pri_nz;
            plic_arbiter #(
                .IRQ_N   (PLIC_IRQ_N),
                .PRI_W   (PLIC_PRI_W),
                .CLAIM_W (PLIC_CLAIM_W)
            ) u_arb (
                .eligible (elig[gc]),
                .pri      (pri),
                .win_id   (win_id[gc]),
                .win_pri  (win_pri[gc])
            );
        end
    endgenerate

    // Read mux plus claim/complete strobes decoded at the accept edge.
    always_comb begin
        rdata     = '0;
        claim_clr = '0;
        cmpl_hit  = '0;
        for (int k = 0; k < PLIC_IRQ_N; k++) begin
            if (widx == k) rdata = MEM_DATA_W'(pri[k]);
        end
        if (widx == IDX_PEND) rdata = MEM_DATA_W'(pend);
        if (widx == IDX_MODE) rdata = MEM_DATA_W'(mode);
        for (int c = 0; c < PLIC_CTX_N; c++) begin
            if (widx == ctx_idx(PLIC_IRQ_N, c, PLIC_ENABLE_OFS)) rdata = MEM_DATA_W'(en[c]);
            if (widx == ctx_idx(PLIC_IRQ_N, c, PLIC_THRES_OFS))  rdata = MEM_DATA_W'(thr[c]);
            if (widx == ctx_idx(PLIC_IRQ_N, c, PLIC_CLAIM_OFS)) begin
                rdata = MEM_DATA_W'(win_id[c]);
                for (int i = 1; i < PLIC_IRQ_N; i++) begin
                    if (accept && !is_wr && (win_id[c] == PLIC_CLAIM_W'(i)))
                        claim_clr[i] = 1'b1;
                    if (accept && is_wr && (cmpl_word == MEM_DATA_W'(i)) && en[c][i] && gw_closed[i])
                        cmpl_hit[i] = 1'b1;
                end
            end
        end
    end

    // Gateway next state: complete first, then the source event, then claim clear.
    always_comb begin
        pend_n = pend;
        gw_n   = gw_closed;
        cnt_n  = cnt;
        for (int i = 0; i < PLIC_IRQ_N; i++) begin
            if (mode[i]) begin
                if (cmpl_hit[i]) begin
                    if (cnt[i] != '0) begin
                        cnt_n[i]  = cnt[i] - PLIC_EDGE_CNT_W'(1);
                        pend_n[i] = 1'b1;
                    end else begin
                        gw_n[i] = 1'b0;
                    end
                end
                if (rise[i]) begin
                    if (!gw_n[i] && !pend_n[i]) begin
                        pend_n[i] = 1'b1;
                        gw_n[i]   = 1'b1;
                    end else if (cnt_n[i] != '1) begin
                        cnt_n[i] = cnt_n[i] + PLIC_EDGE_CNT_W'(1);
                    end
                end
            end else begin
                if (cmpl_hit[i]) gw_n[i] = 1'b0;
                if (!gw_n[i] && s2[i]) begin
                    pend_n[i] = 1'b1;
                    gw_n[i]   = 1'b1;
                end
            end
            pend_n[i] = pend_n[i] & ~claim_clr[i];
        end
        pend_n[0] = 1'b0;
        gw_n[0]   = 1'b0;
        cnt_n[0]  = '0;
    end

    // Source synchroniser and gateway/pending state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            pend      <= '0;
            gw_closed <= '0;
            cnt       <= '0;
        end else begin
            s1        <= ext_irq_src;
            s2        <= s1;
            s3        <= s2;
            pend      <= pend_n;
            gw_closed <= gw_n;
            cnt       <= cnt_n;
        end
    end

    // Configuration registers, byte-masked writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            pri  <= '0;
            mode <= '0;
            en   <= '0;
            thr  <= '0;
        end else if (accept && is_wr) begin
            for (int k = 1; k < PLIC_IRQ_N; k++) begin
                if (widx == k)
                    pri[k] <= PLIC_PRI_W'(apply_mask(MEM_DATA_W'(pri[k]), mem_req.req_data, mem_req.req_mask));
            end
            if (widx == IDX_MODE)
                mode <= PLIC_IRQ_N'(apply_mask(MEM_DATA_W'(mode), mem_req.req_data, mem_req.req_mask)) & SRC_MASK;
            for (int c = 0; c < PLIC_CTX_N; c++) begin
                if (widx == ctx_idx(PLIC_IRQ_N, c, PLIC_ENABLE_OFS))
                    en[c] <= PLIC_IRQ_N'(apply_mask(MEM_DATA_W'(en[c]), mem_req.req_data, mem_req.req_mask)) & SRC_MASK;
                if (widx == ctx_idx(PLIC_IRQ_N, c, PLIC_THRES_OFS))
                    thr[c] <= PLIC_PRI_W'(apply_mask(MEM_DATA_W'(thr[c]), mem_req.req_data, mem_req.req_mask));
            end
        end
    end

    // Registered interrupt request per context.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_irq <= '0;
        end else begin
            for (int c = 0; c < PLIC_CTX_N; c++) ext_irq[c] <= (win_pri[c] > thr[c]);
        end
    end

    // Single-outstanding bus response holder.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            resp_data <= '0;
        end else if (accept) begin
            busy      <= 1'b1;
            resp_data <= is_wr ? '0 : rdata;
        end else if (busy && mem_resp_ready) begin
            busy <= 1'b0;
        end
    end

endmodule
